mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single byte-wide RAM port between the ICache refill path and the data path.
//  The ICache side issues 4-byte refill bursts at 1 byte/cycle with a pass-through address.
//  The data side issues 1/2/4-byte loads and stores.
//  Round-robin arbitration happens per transaction; a grant is never pre-empted mid-transaction.
// PARAMETERS
//  ADDR_W   17  byte address width
//  I_BURST  4   bytes per ICache refill burst
// PORTS
//  clk       in   1       clock
//  rst       in   1       synchronous reset, active-high
//  ic_req    in   1       ICache wants bytes; held high until the last byte returns
//  ic_addr   in   ADDR_W  ICache byte address; advances combinationally on ic_valid
//  ic_valid  out  1       ic_data holds the byte for the address issued last cycle
//  ic_data   out  8       returned byte (pass-through of mem_din)
//  dc_req    in   1       data request; level, held until dc_done
//  dc_we     in   1       1 = store, 0 = load
//  dc_size   in   2       00 byte, 01 half, 10/11 word
//  dc_addr   in   ADDR_W  data byte address
//  dc_wdata  in   32      store data, little-endian
//  dc_done   out  1       one-cycle completion pulse
//  dc_rdata  out  32      load result, zero-extended; stable until the next dc_done
//  mem_din   in   8       RAM read data; 1-cycle latency after issue
//  mem_wait  in   1       RAM busy: no issue this cycle
//  mem_dout  out  8       RAM write data
//  mem_a     out  ADDR_W  RAM address
//  mem_wr    out  1       RAM write enable
// BEHAVIOUR
//  Reset: state IDLE, counters 0, last_grant=D (so I wins the first tie).
//   ic_valid=0, dc_done=0, dc_rdata=0, mem_wr=0, mem_a=0, mem_dout=0.
//  States: IDLE, IREAD, DREAD, DWRITE.
//  IDLE: mem_a=0, mem_wr=0.
//   - Grant only ic_req -> I; only dc_req -> D; both -> the side != last_grant.
//   - dc_req is ignored in any cycle where dc_done=1 (requester is still dropping it).
//   - D grant latches addr/size/we/wdata and sets N = 1, 2 or 4.
//   - The grant is registered; the first issue occurs in the next cycle.
//  Issue: one byte per cycle when !mem_wait.
//   - A stalled cycle drives mem_wr=0 and does not advance the issue counter.
//  IREAD:
//   - mem_a = ic_addr (combinational pass-through); issue while issued < I_BURST.
//   - ic_valid is registered: 1 in the cycle after each issue; ic_data = mem_din.
//   - The cycle the I_BURST-th byte is valid: next state IDLE, last_grant=I.
//  DREAD:
//   - mem_a = latched addr + k (k = 0..N-1, wraps modulo 2^ADDR_W).
//   - Byte k is captured into dc_rdata[8k+7:8k]; unused upper bytes are 0.
//   - The cycle after the last byte is captured: dc_done=1, state IDLE, last_grant=D.
//  DWRITE:
//   - mem_a = latched addr + k; mem_wr=1; mem_dout = wdata[8k+7:8k].
//   - The cycle after the last write issue: dc_done=1, state IDLE, last_grant=D.
//  Word read, no stalls:
//   - grant @0; issue @1-4; data @2-5; dc_done @6.
//   - I burst has the same timing, with ic_valid @2-5.
//  The ICache idiom (addr = base + fill + valid) must equal the sequential issue order, stalls included.
//  Reset mid-transaction: in-flight bytes are discarded.
//   - No ic_valid or dc_done in the cycle after reset.
//   - A D write may be partially done; this is accepted.
//  ic_valid/dc_done never both 1; at most one mem issue per cycle.
// TESTING
//  - ic_req, ic_addr 0x00100 (+fill idiom), mem returns addr[7:0]
//    -> mem_a 0x100-0x103 @1-4; ic_valid @2-5 with 00,01,02,03; IDLE @6.
//  - DREAD word @0x00200, RAM bytes 11,22,33,44
//    -> dc_done @6, dc_rdata=0x44332211; byte load @0x203 -> dc_rdata=0x00000044.
//  - DWRITE half @0x1FFFF, wdata 0xABCD, mem_wait=1 on the cycle of byte 1
//    -> writes CD @0x1FFFF, then AB @0x00000 one cycle late; dc_done after.
//  - ic_req and dc_req high together out of reset -> I served first, D next.
//    Repeat requests alternate I, D, I, D; neither side ever waits two transactions.
//  - rst asserted @3 of an I burst -> next cycle all outputs 0, state IDLE.
//    A fresh ic_req is then granted and served normally.
//  - dc_req held through dc_done for one extra cycle -> no duplicate transaction.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin sharing of one byte-wide RAM port between ICache refill bursts and
// 1/2/4-byte data loads/stores; a granted transaction always runs to completion.
module mem_arbiter #(
    parameter int ADDR_W  = 17,
    parameter int I_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_valid,
    output logic [7:0]        ic_data,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [1:0]        dc_size,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [31:0]       dc_wdata,
    output logic              dc_done,
    output logic [31:0]       dc_rdata,
    input  logic [7:0]        mem_din,
    input  logic              mem_wait,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    output logic [1:0]        dbg_state
);
    // Handshake: ic_req/dc_req are levels held until ic_valid of the last byte /
    // dc_done; one byte issues per cycle with mem_wait low, read data lands a cycle later.
    localparam int CW = (I_BURST > 4) ? $clog2(I_BURST + 1) : 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IREAD  = 2'd1,
        DREAD  = 2'd2,
        DWRITE = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic              last_i;
    logic [CW-1:0]     iss_cnt, n_bytes;
    logic [ADDR_W-1:0] d_addr, d_cur_addr;
    logic [31:0]       d_wdata, rd_buf, rd_merged;
    logic              rd_pend, issue, dc_req_eff, grant_d;
    logic              i_fin, rd_fin, wr_fin;
    logic [1:0]        cap_idx;

    assign dbg_state = state;
    assign ic_data   = ic_valid ? mem_din : 8'h00;

    always_comb begin
        state_nx   = state;
        issue      = 1'b0;
        grant_d    = 1'b0;
        i_fin      = 1'b0;
        rd_fin     = 1'b0;
        wr_fin     = 1'b0;
        mem_a      = '0;
        mem_wr     = 1'b0;
        mem_dout   = 8'h00;
        // The requester is still dropping dc_req during its own done pulse.
        dc_req_eff = dc_req && !dc_done;
        // Byte captured this cycle was issued last cycle, i.e. index iss_cnt-1.
        cap_idx    = iss_cnt[1:0] - 2'd1;
        d_cur_addr = d_addr + ADDR_W'(iss_cnt);
        rd_merged  = rd_buf;
        rd_merged[{cap_idx, 3'b000} +: 8] = mem_din;
        case (state)
            IDLE: begin
                if (ic_req && (!dc_req_eff || !last_i)) begin
                    state_nx = IREAD;
                end else if (dc_req_eff) begin
                    grant_d  = 1'b1;
                    state_nx = dc_we ? DWRITE : DREAD;
                end
            end
            IREAD: begin
                if (iss_cnt < CW'(I_BURST)) begin
                    mem_a = ic_addr;
                    issue = !mem_wait;
                end
                if (ic_valid && iss_cnt == CW'(I_BURST)) begin
                    i_fin    = 1'b1;
                    state_nx = IDLE;
                end
            end
            DREAD: begin
                if (iss_cnt < n_bytes) begin
                    mem_a = d_cur_addr;
                    issue = !mem_wait;
                end
                if (rd_pend && iss_cnt == n_bytes) begin
                    rd_fin   = 1'b1;
                    state_nx = IDLE;
                end
            end
            DWRITE: begin
                if (iss_cnt < n_bytes) begin
                    mem_a    = d_cur_addr;
                    mem_dout = d_wdata[{iss_cnt[1:0], 3'b000} +: 8];
                    mem_wr   = !mem_wait;
                    issue    = !mem_wait;
                end
                if (issue && iss_cnt == n_bytes - CW'(1)) begin
                    wr_fin   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_i   <= 1'b0;
            iss_cnt  <= '0;
            n_bytes  <= '0;
            d_addr   <= '0;
            d_wdata  <= '0;
            rd_buf   <= '0;
            rd_pend  <= 1'b0;
            ic_valid <= 1'b0;
            dc_done  <= 1'b0;
            dc_rdata <= '0;
        end else begin
            state    <= state_nx;
            ic_valid <= issue && (state == IREAD);
            rd_pend  <= issue && (state == DREAD);
            dc_done  <= rd_fin || wr_fin;
            if (state == IDLE) begin
                iss_cnt <= '0;
            end else if (issue) begin
                iss_cnt <= iss_cnt + CW'(1);
            end
            if (grant_d) begin
                d_addr  <= dc_addr;
                d_wdata <= dc_wdata;
                rd_buf  <= '0;
                case (dc_size)
                    2'b00:   n_bytes <= CW'(1);
                    2'b01:   n_bytes <= CW'(2);
                    default: n_bytes <= CW'(4);
                endcase
            end else if (rd_pend) begin
                rd_buf <= rd_merged;
            end
            if (rd_fin) begin
                dc_rdata <= rd_merged;
            end
            if (i_fin) begin
                last_i <= 1'b1;
            end else if (rd_fin || wr_fin) begin
                last_i <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: requester tasks drive both sides, a byte RAM model
// answers, and a negedge monitor pops expected events from exp_q.
module tb_mem_arbiter;
    localparam int ADDR_W  = 17;
    localparam int I_BURST = 4;
    localparam int EW      = 2 + 16 + ADDR_W + 32;
    localparam logic [1:0] EV_IC  = 2'd0;
    localparam logic [1:0] EV_DC  = 2'd1;
    localparam logic [1:0] EV_WR  = 2'd2;
    localparam logic [1:0] EV_DCW = 2'd3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ic_req = 1'b0;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_valid;
    logic [7:0]        ic_data;
    logic              dc_req = 1'b0;
    logic              dc_we = 1'b0;
    logic [1:0]        dc_size = 2'b00;
    logic [ADDR_W-1:0] dc_addr = '0;
    logic [31:0]       dc_wdata = '0;
    logic              dc_done;
    logic [31:0]       dc_rdata;
    logic [7:0]        mem_din = 8'h00;
    logic              mem_wait = 1'b0;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic [1:0]        dbg_state;

    logic [7:0]        ram [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] ic_base = '0;
    logic [2:0]        ic_fill = 3'd0;
    logic [EW-1:0]     exp_q[$];
    int                cyc = 0;
    int                n_vec = 0;
    int                n_err = 0;
    int                g;

    mem_arbiter #(.ADDR_W(ADDR_W), .I_BURST(I_BURST)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_data(ic_data),
        .dc_req(dc_req), .dc_we(dc_we), .dc_size(dc_size), .dc_addr(dc_addr),
        .dc_wdata(dc_wdata), .dc_done(dc_done), .dc_rdata(dc_rdata),
        .mem_din(mem_din), .mem_wait(mem_wait), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / environment ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ICache idiom: address = base + bytes received + byte arriving now.
    assign ic_addr = ic_base + ADDR_W'(ic_fill) + ADDR_W'(ic_valid);

    always @(posedge clk) begin
        if (!ic_req) ic_fill <= 3'd0;
        else if (ic_valid) ic_fill <= ic_fill + 3'd1;
    end

    always @(posedge clk) begin
        mem_din <= ram[mem_a];
        if (mem_wr && !mem_wait) ram[mem_a] <= mem_dout;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    function automatic logic [EW-1:0] ev(input logic [1:0] k, input int c,
                                         input logic [ADDR_W-1:0] a, input logic [31:0] d);
        logic [15:0] c16;
        c16 = c[15:0];
        return {k, c16, a, d};
    endfunction

    task automatic push(input logic [1:0] k, input int c, input logic [ADDR_W-1:0] a,
                        input logic [31:0] d);
        exp_q.push_back(ev(k, c, a, d));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [EW-1:0] act;
        logic [EW-1:0] e;
        if (ic_valid || dc_done || mem_wr) begin
            n_vec++;
            if (ic_valid)     act = ev(EV_IC, cyc, '0, {24'h0, ic_data});
            else if (dc_done) act = ev(EV_DC, cyc, '0, dc_rdata);
            else              act = ev(EV_WR, cyc, mem_a, {24'h0, mem_dout});
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: got %h, expected none (cycle %0d)", act, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e[EW-1 -: 2] == EV_DCW && act[EW-1 -: 2] == EV_DC)
                    act = ev(EV_DCW, cyc, '0, 32'h0);
                if (act !== e) begin
                    n_err++;
                    $display("FAIL event: got kind/cyc/addr/data %h, expected %h (cycle %0d)",
                             act, e, cyc);
                end
            end
            if (ic_valid && dc_done) begin
                n_vec++;
                n_err++;
                $display("FAIL exclusive: got ic_valid=1 dc_done=1, expected at most one (cycle %0d)", cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ic_run(input logic [ADDR_W-1:0] base, input int stall_rel);
        int t0;
        bit ok;
        t0 = cyc;
        ok = 1'b0;
        ic_base = base;
        ic_req = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (stall_rel >= 0) mem_wait = (cyc == t0 + stall_rel);
            if (ic_fill == 3'(I_BURST)) ok = 1'b1;
        end
        ic_req = 1'b0;
        if (stall_rel >= 0) mem_wait = 1'b0;
        check("ic_burst_complete", {31'h0, ok}, 32'h1);
        check("ic_end_state_idle", {30'h0, dbg_state}, 32'h0);
    endtask

    task automatic dc_run(input logic we, input logic [1:0] size, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wdata, input int stall_rel, input bit hold_extra);
        int t0;
        bit ok;
        t0 = cyc;
        ok = 1'b0;
        dc_we = we;
        dc_size = size;
        dc_addr = addr;
        dc_wdata = wdata;
        dc_req = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (stall_rel >= 0) mem_wait = (cyc == t0 + stall_rel);
            if (dc_done) ok = 1'b1;
        end
        if (hold_extra) idle(1);
        dc_req = 1'b0;
        if (stall_rel >= 0) mem_wait = 1'b0;
        check("dc_done_seen", {31'h0, ok}, 32'h1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = 8'(a);
        ram[17'h00200] = 8'h11;
        ram[17'h00201] = 8'h22;
        ram[17'h00202] = 8'h33;
        ram[17'h00203] = 8'h44;

        idle(3);
        rst = 1'b0;
        check("rst_state", {30'h0, dbg_state}, 32'h0);
        check("rst_ic_valid", {31'h0, ic_valid}, 32'h0);
        check("rst_dc_done", {31'h0, dc_done}, 32'h0);
        check("rst_dc_rdata", dc_rdata, 32'h0);
        check("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
        check("rst_mem_a", {15'h0, mem_a}, 32'h0);
        check("rst_mem_dout", {24'h0, mem_dout}, 32'h0);

        // both request out of reset: I first, D right after
        g = cyc;
        push(EV_IC, g + 2, '0, 32'h20);
        push(EV_IC, g + 3, '0, 32'h21);
        push(EV_IC, g + 4, '0, 32'h22);
        push(EV_IC, g + 5, '0, 32'h23);
        push(EV_DC, g + 12, '0, 32'h44332211);
        fork
            ic_run(17'h00120, -1);
            dc_run(1'b0, 2'b10, 17'h00200, 32'h0, -1, 1'b0);
        join

        // tie again after D: I wins, then byte load at 0x203
        idle(1);
        g = cyc;
        push(EV_IC, g + 2, '0, 32'h24);
        push(EV_IC, g + 3, '0, 32'h25);
        push(EV_IC, g + 4, '0, 32'h26);
        push(EV_IC, g + 5, '0, 32'h27);
        push(EV_DC, g + 9, '0, 32'h00000044);
        fork
            ic_run(17'h00124, -1);
            dc_run(1'b0, 2'b00, 17'h00203, 32'h0, -1, 1'b0);
        join

        // I alone at 0x100: bytes 00..03, IDLE six cycles after grant
        idle(1);
        g = cyc;
        push(EV_IC, g + 2, '0, 32'h00);
        push(EV_IC, g + 3, '0, 32'h01);
        push(EV_IC, g + 4, '0, 32'h02);
        push(EV_IC, g + 5, '0, 32'h03);
        ic_run(17'h00100, -1);
        check("ic_idle_cycle", cyc - g, 32'd6);

        // tie after I: D wins, I follows
        idle(1);
        g = cyc;
        push(EV_DC, g + 6, '0, 32'h07060504);
        push(EV_IC, g + 8, '0, 32'h30);
        push(EV_IC, g + 9, '0, 32'h31);
        push(EV_IC, g + 10, '0, 32'h32);
        push(EV_IC, g + 11, '0, 32'h33);
        fork
            ic_run(17'h00130, -1);
            dc_run(1'b0, 2'b10, 17'h00204, 32'h0, -1, 1'b0);
        join

        // half load
        idle(1);
        g = cyc;
        push(EV_DC, g + 4, '0, 32'h00003322);
        dc_run(1'b0, 2'b01, 17'h00201, 32'h0, -1, 1'b0);

        // half store across the address wrap, stall on byte 1
        idle(1);
        g = cyc;
        push(EV_WR, g + 1, 17'h1FFFF, 32'hCD);
        push(EV_WR, g + 3, 17'h00000, 32'hAB);
        push(EV_DCW, g + 4, '0, 32'h0);
        dc_run(1'b1, 2'b01, 17'h1FFFF, 32'h0000ABCD, 2, 1'b0);

        // word read back across the wrap
        idle(1);
        g = cyc;
        push(EV_DC, g + 6, '0, 32'h0201ABCD);
        dc_run(1'b0, 2'b11, 17'h1FFFF, 32'h0, -1, 1'b0);

        // I burst with a stall in cycle 2: idiom address must not skip
        idle(1);
        g = cyc;
        push(EV_IC, g + 2, '0, 32'h50);
        push(EV_IC, g + 4, '0, 32'h51);
        push(EV_IC, g + 5, '0, 32'h52);
        push(EV_IC, g + 6, '0, 32'h53);
        ic_run(17'h00150, 2);

        // reset in cycle 3 of an I burst
        idle(1);
        g = cyc;
        push(EV_IC, g + 2, '0, 32'h60);
        push(EV_IC, g + 3, '0, 32'h61);
        ic_base = 17'h00160;
        ic_req = 1'b1;
        idle(3);
        rst = 1'b1;
        ic_req = 1'b0;
        idle(1);
        rst = 1'b0;
        check("mid_rst_state", {30'h0, dbg_state}, 32'h0);
        check("mid_rst_ic_valid", {31'h0, ic_valid}, 32'h0);
        check("mid_rst_ic_data", {24'h0, ic_data}, 32'h0);
        check("mid_rst_dc_done", {31'h0, dc_done}, 32'h0);
        check("mid_rst_dc_rdata", dc_rdata, 32'h0);
        check("mid_rst_mem_wr", {31'h0, mem_wr}, 32'h0);
        check("mid_rst_mem_a", {15'h0, mem_a}, 32'h0);
        check("mid_rst_mem_dout", {24'h0, mem_dout}, 32'h0);

        // fresh burst after the reset
        idle(1);
        g = cyc;
        push(EV_IC, g + 2, '0, 32'h80);
        push(EV_IC, g + 3, '0, 32'h81);
        push(EV_IC, g + 4, '0, 32'h82);
        push(EV_IC, g + 5, '0, 32'h83);
        ic_run(17'h00180, -1);

        // dc_req held one cycle past dc_done: no second transaction
        idle(1);
        g = cyc;
        push(EV_DC, g + 3, '0, 32'h00000033);
        dc_run(1'b0, 2'b00, 17'h00202, 32'h0, -1, 1'b1);
        idle(8);
        check("post_hold_state", {30'h0, dbg_state}, 32'h0);

        while (exp_q.size() != 0) begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_event: got nothing, expected %h", e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
